// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: SPARC-style PC/nPC pair with delayed/annulled redirect,
// feeding ID through a small FIFO of {pc, npc, instruction} entries.
module if_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              ADDR_W   = 9,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    R_n,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic [31:0]             imem_data,
  input  logic                    redirect,
  input  logic                    annul,
  input  logic [XLEN-1:0]         delay_pc,
  input  logic [XLEN-1:0]         target,
  input  logic                    id_ready,
  output logic                    id_valid,
  output logic [31:0]             id_instr,
  output logic [XLEN-1:0]         id_pc,
  output logic [XLEN-1:0]         id_npc,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    misalign
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam int              OCC_W   = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);
  localparam logic [XLEN-1:0] FOUR    = XLEN'(4);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  npc_q, npc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             misalign_q, misalign_d;

  logic [XLEN-1:0]  pcMem   [DEPTH];
  logic [XLEN-1:0]  npcMem  [DEPTH];
  logic [31:0]      instrMem[DEPTH];

  logic             notEmpty;
  logic             pop;
  logic             push;
  logic [XLEN-1:0]  delayAligned;
  logic [XLEN-1:0]  targetAligned;

  assign notEmpty      = (occ_q != '0);
  assign pop           = notEmpty & id_ready;
  assign push          = !redirect & ((occ_q < DEPTH_C) | pop);
  assign delayAligned  = {delay_pc[XLEN-1:2], 2'b00};
  assign targetAligned = {target[XLEN-1:2], 2'b00};

  always_comb begin
    pc_d       = pc_q;
    npc_d      = npc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    misalign_d = 1'b0;
    if (redirect) begin
      // Redirect flushes everything queued, including an entry ID takes this cycle.
      head_d     = '0;
      tail_d     = '0;
      occ_d      = '0;
      misalign_d = (delay_pc[1:0] != 2'b00) || (target[1:0] != 2'b00);
      if (annul) begin
        pc_d  = targetAligned;
        npc_d = targetAligned + FOUR;
      end else begin
        pc_d  = delayAligned;
        npc_d = targetAligned;
      end
    end else begin
      if (push) begin
        pc_d   = npc_q;
        npc_d  = npc_q + FOUR;
        tail_d = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      if (push && !pop) begin
        occ_d = occ_q + 1'b1;
      end else if (pop && !push) begin
        occ_d = occ_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!R_n) begin
      pc_q       <= RESET_PC;
      npc_q      <= RESET_PC + FOUR;
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      npc_q      <= npc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      misalign_q <= misalign_d;
    end
  end

  // Entry storage needs no reset: outputs are gated by the occupancy counter.
  always_ff @(posedge clk) begin
    if (R_n && push) begin
      pcMem[tail_q]    <= pc_q;
      npcMem[tail_q]   <= npc_q;
      instrMem[tail_q] <= imem_data;
    end
  end

  assign imem_addr = pc_q[ADDR_W-1:0];
  assign id_valid  = notEmpty;
  assign id_pc     = notEmpty ? pcMem[head_q]    : '0;
  assign id_npc    = notEmpty ? npcMem[head_q]   : '0;
  assign id_instr  = notEmpty ? instrMem[head_q] : '0;
  assign occupancy = occ_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed self-checking bench for if_fetch_queue with default parameters
// (DEPTH=2, RESET_PC=0) and a word-per-address instruction ROM model.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        R_n;
  logic [8:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic        annul;
  logic [31:0] delay_pc;
  logic [31:0] target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_npc;
  logic [1:0]  occupancy;
  logic        misalign;

  int compared   = 0;
  int mismatched = 0;

  if_fetch_queue dut (
    .clk       (clk),
    .R_n       (R_n),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .redirect  (redirect),
    .annul     (annul),
    .delay_pc  (delay_pc),
    .target    (target),
    .id_ready  (id_ready),
    .id_valid  (id_valid),
    .id_instr  (id_instr),
    .id_pc     (id_pc),
    .id_npc    (id_npc),
    .occupancy (occupancy),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  // ROM: the word at byte address a is 0x01000000 + a, so instruction 0 is a nop.
  assign imem_data = 32'h0100_0000 + {23'd0, imem_addr};

  function automatic logic [31:0] expInstr(input logic [31:0] pc);
    return 32'h0100_0000 | (pc & 32'h0000_01FF);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst_n, input logic redir, input logic ann,
                               input logic [31:0] dpc, input logic [31:0] tgt,
                               input logic rdy);
    R_n      = rst_n;
    redirect = redir;
    annul    = ann;
    delay_pc = dpc;
    target   = tgt;
    id_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkHead(input string tag, input logic [31:0] pc, input logic [31:0] npc);
    checkOutput({tag, ".valid"}, {63'd0, id_valid}, 64'd1);
    checkOutput({tag, ".pc"},    {32'd0, id_pc},    {32'd0, pc});
    checkOutput({tag, ".npc"},   {32'd0, id_npc},   {32'd0, npc});
    checkOutput({tag, ".instr"}, {32'd0, id_instr}, {32'd0, expInstr(pc)});
  endtask

  task automatic checkEmpty(input string tag);
    checkOutput({tag, ".valid"}, {63'd0, id_valid},  64'd0);
    checkOutput({tag, ".occ"},   {62'd0, occupancy}, 64'd0);
    checkOutput({tag, ".pc"},    {32'd0, id_pc},     64'd0);
    checkOutput({tag, ".instr"}, {32'd0, id_instr},  64'd0);
  endtask

  initial begin
    // Reset held two cycles, with a redirect that must be ignored.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h14, 32'h40, 1'b1);
    tick();
    checkEmpty("rst1");
    tick();
    checkEmpty("rst2");
    checkOutput("rst.addr", {55'd0, imem_addr}, 64'd0);
    checkOutput("rst.mis",  {63'd0, misalign},  64'd0);

    // Streaming after reset release: heads 0, 4, 8, 12 back-to-back.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    checkHead("first", 32'd0, 32'd4);
    checkOutput("first.instr0", {32'd0, id_instr}, 64'h0100_0000);
    tick();
    checkHead("s4", 32'd4, 32'd8);
    tick();
    checkHead("s8", 32'd8, 32'd12);
    tick();
    checkHead("s12", 32'd12, 32'd16);
    checkOutput("s12.occ", {62'd0, occupancy}, 64'd1);

    // Backpressure: fill, hold, then drain in order.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    checkOutput("bp.occ1", {62'd0, occupancy}, 64'd1);
    tick();
    checkOutput("bp.occ2", {62'd0, occupancy}, 64'd2);
    checkOutput("bp.addr2", {55'd0, imem_addr}, 64'd8);
    tick();
    checkOutput("bp.hold.occ", {62'd0, occupancy}, 64'd2);
    checkOutput("bp.hold.addr", {55'd0, imem_addr}, 64'd8);
    checkHead("bp.h0", 32'd0, 32'd4);
    id_ready = 1'b1;
    tick();
    checkHead("bp.h4", 32'd4, 32'd8);
    checkOutput("bp.fullpop.occ", {62'd0, occupancy}, 64'd2);
    tick();
    checkHead("bp.h8", 32'd8, 32'd12);

    // Delayed branch while full, no pop.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h14, 32'h40, 1'b0);
    tick();
    checkEmpty("br");
    checkOutput("br.addr", {55'd0, imem_addr}, 64'h14);
    checkOutput("br.mis",  {63'd0, misalign},  64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    checkHead("br.ds", 32'h14, 32'h40);
    tick();
    checkHead("br.t", 32'h40, 32'h44);
    tick();
    checkHead("br.t4", 32'h44, 32'h48);

    // Annulled branch with a same-cycle pop: delay slot 0x14 is skipped.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h14, 32'h80, 1'b1);
    tick();
    checkEmpty("an");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    checkHead("an.t", 32'h80, 32'h84);
    tick();
    checkHead("an.t4", 32'h84, 32'h88);

    // Fill, then redirect + pop + full together, to a misaligned target.
    id_ready = 1'b0;
    tick();
    checkOutput("sim.occ2", {62'd0, occupancy}, 64'd2);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h100, 32'h42, 1'b1);
    tick();
    checkEmpty("sim");
    checkOutput("sim.addr", {55'd0, imem_addr}, 64'h40);
    checkOutput("sim.mis",  {63'd0, misalign},  64'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    checkOutput("sim.mis.off", {63'd0, misalign}, 64'd0);
    checkHead("sim.t", 32'h40, 32'h44);

    // nPC wrap-around at the top of the address space.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFC, 1'b1);
    tick();
    checkOutput("wrap.addr", {55'd0, imem_addr}, 64'h1FC);
    checkOutput("wrap.mis",  {63'd0, misalign},  64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    checkHead("wrap.top", 32'hFFFF_FFFC, 32'h0);
    tick();
    checkHead("wrap.zero", 32'h0, 32'h4);

    // Mid-operation reset with a full FIFO and a pending redirect.
    id_ready = 1'b0;
    tick();
    checkOutput("mr.occ2", {62'd0, occupancy}, 64'd2);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h80, 1'b1);
    tick();
    checkEmpty("mr");
    checkOutput("mr.npc",  {32'd0, id_npc},    64'd0);
    checkOutput("mr.addr", {55'd0, imem_addr}, 64'd0);
    checkOutput("mr.mis",  {63'd0, misalign},  64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    checkHead("mr.first", 32'd0, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
